// File: rtl/linked_list_fifo_scheduler_pkg.sv
// Shared types and helpers for the linked-list FIFO scheduler.
// Latency: n/a (types, constants and elaboration-time functions only).
// Backpressure: n/a.
package linked_list_fifo_scheduler_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 32;
  localparam int DEF_FIFOS = 8;

  // Bits needed to hold v (minimum 1); log2(FIFOS-1) gives the queue-id width.
  function automatic int log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((v >> i) != 0) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  // The linked-list RAM walks every entry plus two setup cycles after reset.
  function automatic int init_cycles(input int depth);
    return depth + 2;
  endfunction

endpackage

// File: rtl/linked_list_fifo_scheduler_rr_arbiter.sv
// Round-robin arbiter: first requester after the last grant wins.
// Latency: purely combinational.
// Backpressure: none; caller decides whether to act on the grant.
module rr_arbiter
  import linked_list_fifo_scheduler_pkg::*;
#(
  parameter int N    = DEF_FIFOS,
  parameter int LOGN = log2(DEF_FIFOS - 1)
) (
  input  logic [N-1:0]    req,
  input  logic [LOGN-1:0] last,
  output logic [N-1:0]    grant,
  output logic [LOGN-1:0] grant_idx,
  output logic            any_grant
);

  logic [LOGN-1:0] idx;

  // Scan last+1 .. last+N; LOGN-bit addition wraps modulo N (N is a power of 2).
  always_comb begin
    any_grant = 1'b0;
    grant_idx = last;
    idx       = last;
    for (int i = 1; i <= N; i++) begin
      idx = last + LOGN'(i);
      if (!any_grant && req[idx]) begin
        any_grant = 1'b1;
        grant_idx = idx;
      end
    end
    grant = any_grant ? (N'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/linked_list_fifo_scheduler.sv
// Scheduler in front of a shared linked-list FIFO: admits pushes, RR-pops non-empty enabled queues.
// Latency: ll_pop -> out_valid is 2 cycles; sustained 1 word/cycle with out_ready held high.
// Backpressure: in_ready drops when no free entries remain; pops stop when the 2-entry output buffer would overflow.
module linked_list_fifo_scheduler
  import linked_list_fifo_scheduler_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int FIFOS      = DEF_FIFOS,
  parameter int LOG2_FIFOS = log2(FIFOS - 1),
  parameter int LOG2_DEPTH = log2(DEPTH - 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic [LOG2_FIFOS-1:0]            in_fifo,
  input  logic [WIDTH-1:0]                 in_d,
  output logic                             in_ready,
  input  logic [FIFOS-1:0]                 q_enable,
  output logic                             out_valid,
  output logic [LOG2_FIFOS-1:0]            out_fifo,
  output logic [WIDTH-1:0]                 out_data,
  input  logic                             out_ready,
  output logic [FIFOS*(LOG2_DEPTH+1)-1:0]  q_count,
  output logic                             ll_push,
  output logic [LOG2_FIFOS-1:0]            ll_push_fifo,
  output logic [WIDTH-1:0]                 ll_d,
  output logic                             ll_pop,
  output logic [LOG2_FIFOS-1:0]            ll_pop_fifo,
  input  logic [WIDTH-1:0]                 ll_q
);

  localparam int CW = LOG2_DEPTH + 1;
  localparam int SW = CW + LOG2_FIFOS;
  localparam logic [CW-1:0] INIT_LAST = CW'(init_cycles(DEPTH) - 1);
  // One entry per queue is held back by the linked list as its tail sentinel.
  localparam logic [CW-1:0] FREE_INIT = CW'(DEPTH - FIFOS);

  typedef struct packed {
    logic [LOG2_FIFOS-1:0] fifo;
    logic [WIDTH-1:0]      data;
  } ob_ent_t;

  state_t                state;
  logic [CW-1:0]         init_cnt;
  logic [CW-1:0]         count [FIFOS];
  logic [CW-1:0]         free;
  logic [LOG2_FIFOS-1:0] rr_ptr;
  logic                  infl_vld;
  logic [LOG2_FIFOS-1:0] infl_tag;
  logic [1:0]            ob_cnt;
  ob_ent_t               ob [2];
  ob_ent_t               new_ent;

  logic                  run, push, pop, deq, slot_ok;
  logic [FIFOS-1:0]      req, grant;
  logic [LOG2_FIFOS-1:0] grant_idx;
  logic                  any_grant;
  logic [SW-1:0]         occ_sum;

  rr_arbiter #(.N(FIFOS), .LOGN(LOG2_FIFOS)) u_arb (
    .req       (req),
    .last      (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // Admission, eligibility and output-slot accounting; a reset cycle issues nothing.
  always_comb begin
    run      = (state == ST_RUN) && !rst;
    in_ready = run && (free != '0);
    push     = in_valid && in_ready;
    for (int i = 0; i < FIFOS; i++) req[i] = (count[i] != '0) && q_enable[i];
    deq      = out_valid && out_ready;
    slot_ok  = ({1'b0, ob_cnt} + {2'b0, infl_vld} - {2'b0, deq}) < 3'd2;
    pop      = run && any_grant && slot_ok;
    new_ent  = '{fifo: infl_tag, data: ll_q};
  end

  assign ll_push      = push;
  assign ll_push_fifo = in_fifo;
  assign ll_d         = in_d;
  assign ll_pop       = pop;
  assign ll_pop_fifo  = grant_idx;
  assign out_valid    = (ob_cnt != 2'd0);
  assign out_data     = ob[0].data;
  assign out_fifo     = ob[0].fifo;

  for (genvar g = 0; g < FIFOS; g++) begin : g_cnt
    assign q_count[g*CW +: CW] = count[g];
  end

  // INIT covers the linked list's own reset walk, then RUN until the next reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else if (state == ST_INIT) begin
      if (init_cnt == INIT_LAST) state <= ST_RUN;
      else                       init_cnt <= init_cnt + CW'(1);
    end
  end

  // Shadow occupancy: per-queue counts, free entries and the round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFOS; i++) count[i] <= '0;
      free   <= FREE_INIT;
      rr_ptr <= '1;
    end else begin
      for (int i = 0; i < FIFOS; i++) begin
        case ({push && (in_fifo == LOG2_FIFOS'(i)), pop && grant[i]})
          2'b10:   count[i] <= count[i] + CW'(1);
          2'b01:   count[i] <= count[i] - CW'(1);
          default: ;
        endcase
      end
      case ({push, pop})
        2'b10:   free <= free - CW'(1);
        2'b01:   free <= free + CW'(1);
        default: ;
      endcase
      if (pop) rr_ptr <= grant_idx;
    end
  end

  // Capture RAM read data one cycle after the pop into the 2-entry output buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      infl_vld <= 1'b0;
      infl_tag <= '0;
      ob_cnt   <= 2'd0;
      ob[0]    <= '0;
      ob[1]    <= '0;
    end else begin
      infl_vld <= pop;
      if (pop) infl_tag <= grant_idx;
      case (ob_cnt)
        2'd0: begin
          if (infl_vld) begin
            ob[0]  <= new_ent;
            ob_cnt <= 2'd1;
          end
        end
        2'd1: begin
          if (infl_vld && deq) begin
            ob[0] <= new_ent;
          end else if (infl_vld) begin
            ob[1]  <= new_ent;
            ob_cnt <= 2'd2;
          end else if (deq) begin
            ob_cnt <= 2'd0;
          end
        end
        default: begin
          if (deq) begin
            ob[0] <= ob[1];
            if (infl_vld) ob[1]  <= new_ent;
            else          ob_cnt <= 2'd1;
          end
        end
      endcase
    end
  end

  // Every RAM entry is either free or owned by exactly one queue.
  always_comb begin
    occ_sum = SW'(free);
    for (int i = 0; i < FIFOS; i++) occ_sum = occ_sum + SW'(count[i]);
  end

  a_occupancy: assert property (@(posedge clk) disable iff (rst)
    occ_sum == SW'(DEPTH - FIFOS));

endmodule

// File: tb/tb_linked_list_fifo_scheduler.sv
// Directed bench for linked_list_fifo_scheduler with a behavioural linked-list RAM.
// Latency: ll_q returned one cycle after ll_pop by the RAM model.
// Backpressure: out_ready and q_enable driven directly by the stimulus.
module tb_linked_list_fifo_scheduler;

  localparam int W  = 8;
  localparam int D  = 32;
  localparam int F  = 8;
  localparam int LF = 3;
  localparam int CW = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [LF-1:0]     in_fifo;
  logic [W-1:0]      in_d;
  logic              in_ready;
  logic [F-1:0]      q_enable;
  logic              out_valid;
  logic [LF-1:0]     out_fifo;
  logic [W-1:0]      out_data;
  logic              out_ready;
  logic [F*CW-1:0]   q_count;
  logic              ll_push;
  logic [LF-1:0]     ll_push_fifo;
  logic [W-1:0]      ll_d;
  logic              ll_pop;
  logic [LF-1:0]     ll_pop_fifo;
  logic [W-1:0]      ll_q = '0;

  always #5 clk = ~clk;

  linked_list_fifo_scheduler #(.WIDTH(W), .DEPTH(D), .FIFOS(F)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_fifo      (in_fifo),
    .in_d         (in_d),
    .in_ready     (in_ready),
    .q_enable     (q_enable),
    .out_valid    (out_valid),
    .out_fifo     (out_fifo),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .q_count      (q_count),
    .ll_push      (ll_push),
    .ll_push_fifo (ll_push_fifo),
    .ll_d         (ll_d),
    .ll_pop       (ll_pop),
    .ll_pop_fifo  (ll_pop_fifo),
    .ll_q         (ll_q)
  );

  typedef struct packed {
    logic [31:0]   cyc;
    logic [LF-1:0] f;
    logic [W-1:0]  d;
  } out_t;

  out_t          out_log [$];
  logic [LF-1:0] pop_log [$];
  int            pop_cyc [$];
  logic [W-1:0]  mq [F][$];
  int            cyc = 0;
  int            init_strobes = 0;
  logic          in_init = 1'b1;
  int            vectors = 0;
  int            miscompares = 0;

  // Behavioural linked-list RAM plus event logging.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      for (int i = 0; i < F; i++) mq[i].delete();
    end else begin
      if (in_init && (ll_push || ll_pop)) init_strobes = init_strobes + 1;
      if (ll_pop) begin
        ll_q <= mq[ll_pop_fifo].pop_front();
        pop_log.push_back(ll_pop_fifo);
        pop_cyc.push_back(cyc);
      end
      if (ll_push) mq[ll_push_fifo].push_back(ll_d);
      if (out_valid && out_ready) out_log.push_back('{cyc: cyc, f: out_fifo, d: out_data});
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [CW-1:0] cnt(input int i);
    return q_count[i*CW +: CW];
  endfunction

  task automatic push(input logic [LF-1:0] f, input logic [W-1:0] d);
    in_valid = 1'b1;
    in_fifo  = f;
    in_d     = d;
    check("push_ready", {63'b0, in_ready}, 64'd1);
    step(1);
    in_valid = 1'b0;
  endtask

  initial begin
    int n;
    logic [F*CW-1:0] exp_cnt;

    rst = 1'b1; in_valid = 1'b0; in_fifo = '0; in_d = '0;
    q_enable = '0; out_ready = 1'b1;

    // 1: reset values, INIT window length, no strobes during INIT
    step(2);
    check("rst_in_ready", {63'b0, in_ready}, 64'd0);
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_ll_push", {63'b0, ll_push}, 64'd0);
    check("rst_ll_pop", {63'b0, ll_pop}, 64'd0);
    check("rst_q_count", {16'b0, q_count}, 64'd0);
    rst = 1'b0;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      n++;
      step(1);
    end
    in_valid = 1'b0;
    in_init = 1'b0;
    check("init_cycles", 64'(n), 64'd34);
    check("init_strobes", 64'(init_strobes), 64'd0);

    // 2: two words through q3, order and pop->out_valid latency
    q_enable = '1;
    out_log.delete(); pop_log.delete(); pop_cyc.delete();
    push(3'd3, 8'hA1);
    push(3'd3, 8'hA2);
    step(6);
    check("t2_out_n", 64'(out_log.size()), 64'd2);
    if (out_log.size() >= 2) begin
      check("t2_d0", 64'(out_log[0].d), 64'hA1);
      check("t2_f0", 64'(out_log[0].f), 64'd3);
      check("t2_d1", 64'(out_log[1].d), 64'hA2);
      check("t2_lat", 64'(int'(out_log[0].cyc) - pop_cyc[0]), 64'd2);
    end
    check("t2_cnt", {16'b0, q_count}, 64'd0);

    // 3: move rr_ptr to 7, then grant order 0,2,5 twice
    push(3'd7, 8'h77);
    step(5);
    for (int r = 0; r < 2; r++) begin
      q_enable = '0;
      push(3'd0, 8'h10);
      push(3'd2, 8'h12);
      push(3'd5, 8'h15);
      pop_log.delete(); out_log.delete();
      q_enable = '1;
      step(8);
      check("t3_pop_n", 64'(pop_log.size()), 64'd3);
      if (pop_log.size() >= 3) begin
        check("t3_g0", 64'(pop_log[0]), 64'd0);
        check("t3_g1", 64'(pop_log[1]), 64'd2);
        check("t3_g2", 64'(pop_log[2]), 64'd5);
      end
      if (out_log.size() >= 3) check("t3_d2", 64'(out_log[2].d), 64'h15);
    end

    // 4: fill all 24 free entries, in_ready drops, one pop restores it
    q_enable = '0; out_ready = 1'b0;
    out_log.delete();
    for (int i = 0; i < 24; i++) push(LF'(i % F), W'(i));
    check("t4_full", {63'b0, in_ready}, 64'd0);
    for (int i = 0; i < F; i++) exp_cnt[i*CW +: CW] = 6'd3;
    check("t4_counts", {16'b0, q_count}, {16'b0, exp_cnt});
    q_enable = 8'h01;
    #1;
    check("t4_pop", {63'b0, ll_pop}, 64'd1);
    check("t4_pop_q", 64'(ll_pop_fifo), 64'd0);
    step(1);
    q_enable = '0;
    check("t4_ready_back", {63'b0, in_ready}, 64'd1);
    check("t4_cnt0", 64'(cnt(0)), 64'd2);
    step(3);
    check("t4_out_valid", {63'b0, out_valid}, 64'd1);

    // 5: stalled output caps pops at the buffer depth, then drains at 1/cycle
    pop_log.delete();
    q_enable = '1;
    step(8);
    check("t5_pop_n", 64'(pop_log.size()), 64'd1);
    if (pop_log.size() >= 1) check("t5_pop_q", 64'(pop_log[0]), 64'd1);
    check("t5_hold_d", 64'(out_data), 64'd0);
    check("t5_hold_f", 64'(out_fifo), 64'd0);
    check("t5_hold_v", {63'b0, out_valid}, 64'd1);
    out_ready = 1'b1;
    step(40);
    check("t5_out_n", 64'(out_log.size()), 64'd24);
    for (int k = 0; k < out_log.size() && k < 24; k++) begin
      check("t5_d", 64'(out_log[k].d), 64'(k));
      check("t5_f", 64'(out_log[k].f), 64'(k % F));
    end
    if (out_log.size() >= 24)
      check("t5_rate", 64'(out_log[23].cyc - out_log[0].cyc), 64'd23);
    check("t5_empty", {16'b0, q_count}, 64'd0);

    // 6: same-cycle push/pop on q1, then reset mid-stream
    q_enable = '0;
    out_log.delete();
    push(3'd1, 8'h31);
    in_valid = 1'b1; in_fifo = 3'd1; in_d = 8'h32;
    q_enable = 8'h02;
    #1;
    check("t6_push", {63'b0, ll_push}, 64'd1);
    check("t6_pop", {63'b0, ll_pop}, 64'd1);
    check("t6_pop_q", 64'(ll_pop_fifo), 64'd1);
    step(1);
    in_valid = 1'b0;
    check("t6_cnt1", 64'(cnt(1)), 64'd1);
    check("t6_ready", {63'b0, in_ready}, 64'd1);
    step(6);
    check("t6_out_n", 64'(out_log.size()), 64'd2);
    if (out_log.size() >= 2) begin
      check("t6_d0", 64'(out_log[0].d), 64'h31);
      check("t6_d1", 64'(out_log[1].d), 64'h32);
    end
    q_enable = '1; out_ready = 1'b0;
    push(3'd2, 8'h41);
    push(3'd2, 8'h42);
    push(3'd4, 8'h43);
    step(4);
    check("t6_pre_valid", {63'b0, out_valid}, 64'd1);
    check("t6_pre_cnt", 64'(cnt(4)), 64'd1);
    rst = 1'b1;
    step(1);
    check("t6_rst_cnt", {16'b0, q_count}, 64'd0);
    check("t6_rst_valid", {63'b0, out_valid}, 64'd0);
    check("t6_rst_ready", {63'b0, in_ready}, 64'd0);
    rst = 1'b0;
    step(2);
    check("t6_init_ready", {63'b0, in_ready}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
